// File: rtl/assoc_cache.sv
// Two-way set-associative, write-back, write-allocate data cache with per-set LRU,
// dirty-victim write-back and a flush scan; one whole block per memory transfer.
module assoc_cache #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SETS   = 4,
  parameter int WORDS  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ADDR_W-1:0]               address,
  input  logic [DATA_W-1:0]               cpu_writeData,
  input  logic                            read,
  input  logic                            write,
  input  logic                            flush,
  output logic [DATA_W-1:0]               cpu_readData,
  output logic                            busywait,
  output logic [ADDR_W-$clog2(WORDS)-1:0] mem_address,
  output logic [DATA_W*WORDS-1:0]         mem_writedata,
  input  logic [DATA_W*WORDS-1:0]         mem_readdata,
  output logic                            mem_read,
  output logic                            mem_write,
  input  logic                            mem_busywait
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = DATA_W * WORDS;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WRITEBACK = 3'd1;
  localparam logic [2:0] ALLOCATE  = 3'd2;
  localparam logic [2:0] FILL      = 3'd3;
  localparam logic [2:0] FLUSH     = 3'd4;

  logic [BLK_W-1:0] blocks [SETS][2];
  logic [TAG_W-1:0] tags   [SETS][2];
  logic [1:0]       valid  [SETS];
  logic [1:0]       dirty  [SETS];
  logic [SETS-1:0]  lru;

  logic [2:0]       state;
  logic             victim;
  logic [IDX_W:0]   fcount;
  logic [BLK_W-1:0] fill_buf;

  logic [TAG_W-1:0] atag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] flush_set;
  logic             flush_way;
  logic             flush_dirty;
  logic             flush_last;
  logic             access;
  logic             hit0;
  logic             hit1;
  logic             hit;
  logic             hit_way;
  logic             miss_victim;
  logic             write_hit;

  assign atag        = address[ADDR_W-1 -: TAG_W];
  assign idx         = address[OFF_W +: IDX_W];
  assign off         = address[OFF_W-1:0];
  assign flush_set   = fcount[IDX_W:1];
  assign flush_way   = fcount[0];
  assign flush_dirty = valid[flush_set][flush_way] & dirty[flush_set][flush_way];
  assign flush_last  = &fcount;
  assign access      = read | write;

  // Way 0 wins if both ways somehow hold the same tag.
  assign hit0      = valid[idx][0] && (tags[idx][0] == atag);
  assign hit1      = valid[idx][1] && (tags[idx][1] == atag) && !hit0;
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1;
  assign write_hit = (state == IDLE) && !flush && write && hit;

  always_comb begin
    if (!valid[idx][0])      miss_victim = 1'b0;
    else if (!valid[idx][1]) miss_victim = 1'b1;
    else                     miss_victim = lru[idx];
  end

  assign cpu_readData = blocks[idx][hit_way][int'(off)*DATA_W +: DATA_W];
  assign busywait     = (state != IDLE) || flush || (access && !hit);

  always_comb begin
    mem_address   = {atag, idx};
    mem_writedata = blocks[idx][victim];
    if (state == FLUSH) begin
      mem_address   = {tags[flush_set][flush_way], flush_set};
      mem_writedata = blocks[flush_set][flush_way];
    end else if (state == WRITEBACK) begin
      mem_address   = {tags[idx][victim], idx};
    end
  end

  // Control: state, status bits and registered memory requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      fcount    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      victim    <= 1'b0;
      lru       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= 2'b00;
        dirty[s] <= 2'b00;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state <= FLUSH;
          end else if (access && hit) begin
            lru[idx] <= ~hit_way;
            if (write) dirty[idx][hit_way] <= 1'b1;
          end else if (access) begin
            victim <= miss_victim;
            if (valid[idx][miss_victim] && dirty[idx][miss_victim]) begin
              state     <= WRITEBACK;
              mem_write <= 1'b1;
            end else begin
              state    <= ALLOCATE;
              mem_read <= 1'b1;
            end
          end
        end
        WRITEBACK: begin
          if (!mem_busywait) begin
            dirty[idx][victim] <= 1'b0;
            mem_write          <= 1'b0;
            mem_read           <= 1'b1;
            state              <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (!mem_busywait) begin
            mem_read <= 1'b0;
            state    <= FILL;
          end
        end
        FILL: begin
          valid[idx][victim] <= 1'b1;
          dirty[idx][victim] <= 1'b0;
          lru[idx]           <= ~victim;
          state              <= IDLE;
        end
        FLUSH: begin
          // A dirty line costs one cycle to raise mem_write, then the transfer.
          if (mem_write) begin
            if (!mem_busywait) begin
              mem_write                      <= 1'b0;
              dirty[flush_set][flush_way]    <= 1'b0;
              if (flush_last) begin
                fcount <= '0;
                state  <= IDLE;
              end else begin
                fcount <= fcount + 1'b1;
              end
            end
          end else if (flush_dirty) begin
            mem_write <= 1'b1;
          end else if (flush_last) begin
            fcount <= '0;
            state  <= IDLE;
          end else begin
            fcount <= fcount + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: block and tag storage, fill buffer; not reset.
  always_ff @(posedge clock) begin
    if (write_hit)
      blocks[idx][hit_way][int'(off)*DATA_W +: DATA_W] <= cpu_writeData;
    if (state == ALLOCATE && !mem_busywait)
      fill_buf <= mem_readdata;
    if (state == FILL) begin
      blocks[idx][victim] <= fill_buf;
      tags[idx][victim]   <= atag;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: block memory with programmable latency, transaction-level
// cache reference model, directed scenarios and randomized load/store/flush traffic.
module tb_assoc_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  address = '0;
  logic [7:0]  cpu_writeData = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  cpu_readData;
  logic        busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_busywait;

  assoc_cache dut (
    .clock(clock), .reset(reset), .address(address), .cpu_writeData(cpu_writeData),
    .read(read), .write(write), .flush(flush), .cpu_readData(cpu_readData),
    .busywait(busywait), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Block memory: busy for 'lat' cycles of each request, then completes.
  logic [31:0] mem [64];
  int          lat = 2;
  int          cnt = 0;
  logic [5:0]  rd_q[$];
  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];

  assign mem_readdata = mem[mem_address];
  assign mem_busywait = (mem_read || mem_write) && (cnt < lat);

  always @(posedge clock) begin
    if (reset) cnt <= 0;
    else if (mem_read || mem_write) begin
      if (mem_busywait) cnt <= cnt + 1;
      else begin
        cnt <= 0;
        if (mem_write) begin
          mem[mem_address] <= mem_writedata;
          wa_q.push_back(mem_address);
          wd_q.push_back(mem_writedata);
        end else rd_q.push_back(mem_address);
      end
    end
  end

  // Per-cycle protocol checks.
  logic       prev_rd = 1'b0, prev_wr = 1'b0;
  logic [5:0] prev_a = '0;
  logic [31:0] prev_d = '0;
  always @(negedge clock) begin
    if (!reset) begin
      chk("req_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
      if (mem_read || mem_write) chk("busy_with_req", {63'd0, busywait}, 64'd1);
      if (prev_rd && mem_read) chk("rd_addr_stable", {58'd0, mem_address}, {58'd0, prev_a});
      if (prev_wr && mem_write) begin
        chk("wr_addr_stable", {58'd0, mem_address}, {58'd0, prev_a});
        chk("wr_data_stable", {32'd0, mem_writedata}, {32'd0, prev_d});
      end
    end
    prev_rd = mem_read && !reset;
    prev_wr = mem_write && !reset;
    prev_a  = mem_address;
    prev_d  = mem_writedata;
  end

  // Reference model: cache contents per set/way and the memory image it implies.
  bit          m_valid [4][2];
  bit          m_dirty [4][2];
  logic [3:0]  m_tag   [4][2];
  logic [31:0] m_blk   [4][2];
  bit          m_lru   [4];
  logic [31:0] ref_mem [64];
  logic [5:0]  e_wa[$];
  logic [31:0] e_wd[$];
  logic [5:0]  e_ra[$];
  int          e_busy;
  logic [7:0]  last_q;
  int          last_busy;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] q);
    logic [1:0] s;
    logic [3:0] tg;
    int off, w;
    s = a[3:2]; tg = a[7:4]; off = int'(a[1:0]); w = -1;
    e_wa.delete(); e_wd.delete(); e_ra.delete(); e_busy = 0;
    if (m_valid[s][0] && m_tag[s][0] == tg) w = 0;
    else if (m_valid[s][1] && m_tag[s][1] == tg) w = 1;
    if (w < 0) begin
      if (!m_valid[s][0]) w = 0;
      else if (!m_valid[s][1]) w = 1;
      else w = int'(m_lru[s]);
      e_busy = lat + 3;
      if (m_valid[s][w] && m_dirty[s][w]) begin
        e_wa.push_back({m_tag[s][w], s});
        e_wd.push_back(m_blk[s][w]);
        ref_mem[{m_tag[s][w], s}] = m_blk[s][w];
        e_busy += lat + 1;
      end
      e_ra.push_back({tg, s});
      m_blk[s][w] = ref_mem[{tg, s}];
      m_tag[s][w] = tg;
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
    end
    if (wr) begin
      m_blk[s][w][off*8 +: 8] = d;
      m_dirty[s][w] = 1'b1;
    end
    m_lru[s] = (w == 0);
    q = m_blk[s][w][off*8 +: 8];
  endtask

  task automatic compare_traffic();
    chk("wb_count", 64'(wa_q.size()), 64'(e_wa.size()));
    for (int i = 0; i < e_wa.size() && i < wa_q.size(); i++) begin
      chk("wb_addr", {58'd0, wa_q[i]}, {58'd0, e_wa[i]});
      chk("wb_data", {32'd0, wd_q[i]}, {32'd0, e_wd[i]});
    end
    chk("rd_count", 64'(rd_q.size()), 64'(e_ra.size()));
    for (int i = 0; i < e_ra.size() && i < rd_q.size(); i++)
      chk("rd_addr", {58'd0, rd_q[i]}, {58'd0, e_ra[i]});
  endtask

  task automatic do_op(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] q;
    int n;
    model_op(wr, a, d, q);
    @(negedge clock);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    address = a; cpu_writeData = d; write = wr; read = rd | ~wr;
    #1;
    n = 0;
    while (busywait && n < 200) begin
      @(negedge clock); #1; n++;
    end
    chk("op_done", {63'd0, busywait}, 64'd0);
    chk("busy_cycles", 64'(n), 64'(e_busy));
    if (!wr) chk("read_data", {56'd0, cpu_readData}, {56'd0, q});
    last_q = cpu_readData;
    last_busy = n;
    compare_traffic();
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_flush();
    int hold, n;
    e_wa.delete(); e_wd.delete(); e_ra.delete();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          e_wa.push_back({m_tag[s][w], 2'(s)});
          e_wd.push_back(m_blk[s][w]);
          ref_mem[{m_tag[s][w], 2'(s)}] = m_blk[s][w];
          m_dirty[s][w] = 1'b0;
        end
    hold = 10 + 8 * (lat + 2);
    @(negedge clock);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    flush = 1'b1;
    for (int i = 0; i < hold; i++) begin
      #1 chk("flush_busy", {63'd0, busywait}, 64'd1);
      @(negedge clock);
    end
    flush = 1'b0;
    #1;
    n = 0;
    while (busywait && n < 200) begin
      @(negedge clock); #1; n++;
    end
    chk("flush_done", {63'd0, busywait}, 64'd0);
    compare_traffic();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h44332211;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_busywait", {63'd0, busywait}, 64'd0);
    chk("reset_mem_read", {63'd0, mem_read}, 64'd0);
    chk("reset_mem_write", {63'd0, mem_write}, 64'd0);

    lat = 2;
    do_op(1'b0, 1'b1, 8'h00, 8'h00);
    chk("first_fill_addr", {58'd0, rd_q[0]}, 64'h00);
    chk("first_read", {56'd0, last_q}, 64'h11);
    chk("first_busy", 64'(last_busy), 64'd5);
    do_op(1'b0, 1'b1, 8'h03, 8'h00);
    chk("hit_read_03", {56'd0, last_q}, 64'h44);
    chk("hit_no_traffic", 64'(rd_q.size() + wa_q.size()), 64'd0);
    do_op(1'b1, 1'b0, 8'h01, 8'hAA);
    chk("write_hit_busy", 64'(last_busy), 64'd0);
    do_op(1'b0, 1'b1, 8'h01, 8'h00);
    chk("read_back_aa", {56'd0, last_q}, 64'hAA);
    do_op(1'b0, 1'b1, 8'h10, 8'h00);
    do_op(1'b0, 1'b1, 8'h20, 8'h00);
    chk("evict_wb_addr", {58'd0, wa_q[0]}, 64'h00);
    chk("evict_wb_data", {32'd0, wd_q[0]}, 64'h4433AA11);
    chk("evict_fill_addr", {58'd0, rd_q[0]}, 64'h08);
    do_op(1'b0, 1'b1, 8'h10, 8'h00);
    chk("lru_survivor_busy", 64'(last_busy), 64'd0);

    do_op(1'b1, 1'b0, 8'h10, 8'h5A);
    do_op(1'b1, 1'b1, 8'h08, 8'hC3);
    do_flush();
    chk("flush_writes", 64'(wa_q.size()), 64'd2);
    chk("flush_first_set0", {58'd0, wa_q[0]}, 64'h04);
    chk("flush_second_set2", {58'd0, wa_q[1]}, 64'h02);
    do_flush();
    chk("reflush_writes", 64'(wa_q.size()), 64'd0);

    lat = 10;
    do_op(1'b0, 1'b1, 8'h44, 8'h00);
    chk("slow_mem_busy", 64'(last_busy), 64'd13);

    @(negedge clock);
    address = 8'h84; read = 1'b1;
    repeat (3) @(negedge clock);
    #1 chk("alloc_pending", {63'd0, mem_read}, 64'd1);
    @(negedge clock);
    reset = 1'b1; read = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_mem_read", {63'd0, mem_read}, 64'd0);
    chk("abort_busywait", {63'd0, busywait}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    lat = 2;
    do_op(1'b0, 1'b1, 8'h84, 8'h00);
    chk("post_reset_miss", 64'(last_busy), 64'd5);

    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      bit wr;
      if ($urandom_range(0, 29) == 0) begin
        lat = $urandom_range(0, 3);
        do_flush();
      end else begin
        a = 8'($urandom);
        a[7:6] = 2'b00;
        wr = 1'($urandom_range(0, 1));
        lat = $urandom_range(0, 3);
        do_op(wr, 1'($urandom_range(0, 1)), a, 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
